ul_symb_window_gen: RTL and testbench
=====================================

# ul_symb_window_gen

Sits directly downstream of the uplink time-base unit, on its `o_ul_0_*` slot/symbol outputs. It takes those slot/symbol heads and the incoming uplink time-domain IQ stream, strips the cyclic prefix and emits exactly one FFT-length window per symbol. Each window carries start/end markers and slot/symbol tags for the PUSCH dimension-reduction datapath. It also detects and counts symbol-head misalignment against the local sample counter.

## Interface
**Parameters**
- `FFT_LEN`, 4096: samples per symbol body.
- `CP_NORM`, 288: normal CP samples.
- `CP_LONG`, 352: long CP samples.
- `LONG_CP_SYMB`, 0: symbol index (per slot) using the long CP.

**Ports**
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `i_enable` input 1: block enable (register-driven).
- `i_slot_head` input 1: one-cycle pulse from TBU at slot start.
- `i_symb_head` input 1: one-cycle pulse from TBU at symbol start.
- `i_slot_num` input 8: slot number, valid with heads.
- `i_symb_num` input 4: symbol number 0..13, valid with `i_symb_head`.
- `i_iq_vld` input 1: input sample strobe (≤1 sample/cycle; nominally every 2nd cycle at 245.76 MHz).
- `i_iq_data` input 32: {I[15:0], Q[15:0]}.
- `o_iq_vld` output 1: body sample valid.
- `o_iq_data` output 32: body sample.
- `o_sop` output 1: with first body sample.
- `o_eop` output 1: with sample FFT_LEN-1.
- `o_slot_num` output 8: tag latched at symbol start.
- `o_symb_num` output 4: tag latched at symbol start.
- `o_err_align` output 1: one-cycle misalignment pulse.
- `o_err_cnt` output 16: saturating misalignment count.

## Operation
- **States:** IDLE, WAIT_SLOT, CP, BODY, GAP.
- **IDLE**
  - Entered on `rst` or `i_enable`=0 (next cycle, from any state).
  - `i_enable`=1 → WAIT_SLOT.
- **WAIT_SLOT**
  - Ignores all samples.
  - `i_slot_head` together with `i_symb_head` → CP.
  - `i_symb_head` without `i_slot_head` is ignored.
- **Symbol start** (any entry to CP):
  - Latch `i_slot_num` / `i_symb_num`.
  - Load CP length: CP_LONG if `i_symb_num`==LONG_CP_SYMB, else CP_NORM.
  - Clear the 13-bit sample counter.
- **Sample counting:** the first CP sample is the first `i_iq_vld` at or after the `i_symb_head` cycle (same cycle counts). Only valid samples advance the counter.
- **CP:** discard samples; after the last CP sample → BODY.
- **BODY:** forward samples.
  - `o_sop` on body sample 0, `o_eop` on sample FFT_LEN-1, then → GAP.
- **GAP:** discard samples; `i_symb_head` → CP (new symbol).
- **Misalignment:** `i_symb_head` while in CP or BODY (before eop).
  - Pulse `o_err_align`, increment `o_err_cnt` (saturates at 0xFFFF).
  - Abandon the current window with no `o_eop`, restart CP for the new symbol.
- **Simultaneous `i_symb_head` and final body sample:** emit the sample with `o_eop`, then start the new symbol. Not an error.
- **Wrap-around:** 14 symbols per slot. `i_symb_num` wraps 13→0 and `i_slot_num` wraps per TBU; tags are copied verbatim with no checking.
- **Enable drop mid-BODY:** `o_iq_vld` low from the next cycle; no `o_eop`; `o_err_cnt` retained.

## Timing
- **Reset values:** all outputs 0; state IDLE; `o_err_cnt` 0.
- **Latency:** 1 cycle, input sample → `o_iq_vld`/`o_iq_data` (registered). `o_sop`/`o_eop` are aligned with their sample.
- **Tag timing:** `o_slot_num`/`o_symb_num` update 1 cycle after symbol start and hold until the next start.
- **Error timing:** `o_err_align` and the `o_err_cnt` update occur 1 cycle after the offending `i_symb_head`.
- **Flow control:** no backpressure; the downstream consumer must accept every `o_iq_vld`.
- **`rst` mid-window:** outputs 0 on the next cycle; no eop emitted.

## Configuration
- **`UL_SYMB_WIN_ERR_CNT_EN` defined:** the misalignment detector, `o_err_align` and `o_err_cnt` are implemented as above.
- **Macro undefined:**
  - `o_err_align` and `o_err_cnt` tied to 0.
  - Misaligned `i_symb_head` still restarts CP silently; window behaviour is otherwise identical.

## Structure
- **Shared package `ul_timing_pkg`:** state enum, FFT_LEN/CP_NORM/CP_LONG defaults, symbols-per-slot constant (14), sample-counter width.
- **Module:** single module with no sub-module. The CP/body counter and the error counter are small enough to stay inline.

## Test plan
- **Nominal slot:** enable, slot+symb head at symbol 0, `i_iq_vld` every 2nd cycle, 61440 samples → symbol 0 discards 352, symbols 1–13 discard 288. 14 windows of 4096 each with one sop/eop per window; tags 0..13; `o_err_cnt`=0.
- **Misaligned head:** `i_symb_head` at body sample 1000 → `o_err_align` pulse, `o_err_cnt`=1, no eop for the aborted window, next window complete.
- **Head on last body sample:** same cycle as sample 4095 → eop emitted, new CP starts, `o_err_cnt`=0.
- **WAIT_SLOT gating:** symb heads without slot head for 3 symbols → no output; first slot head → windows begin.
- **Enable/reset mid-BODY:** `i_enable`=0 at body sample 2000 → `o_iq_vld`=0 next cycle, no eop. Repeat with `rst` → all outputs 0, `o_err_cnt`=0.
- **Saturation (macro defined):** 65537 misaligned heads → `o_err_cnt`=0xFFFF. With the macro undefined, `o_err_cnt`=0 throughout.

Source files
------------

// File: rtl/ul_timing_pkg.sv
// rtl/ul_timing_pkg.sv - shared uplink timing types, defaults and widths
package ul_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_CP        = 3'd2,
        ST_BODY      = 3'd3,
        ST_GAP       = 3'd4
    } win_state_t;

    localparam int FFT_LEN_DEF   = 4096;
    localparam int CP_NORM_DEF   = 288;
    localparam int CP_LONG_DEF   = 352;
    localparam int SYMB_PER_SLOT = 14;
    localparam int SAMP_CNT_W    = 13;

endpackage

// File: rtl/ul_symb_window_gen.sv
// rtl/ul_symb_window_gen.sv - uplink CP strip / FFT window generator with symbol-head alignment check
// Optional misalignment counter: define UL_SYMB_WIN_ERR_CNT_EN.
module ul_symb_window_gen
    import ul_timing_pkg::*;
#(
    parameter int FFT_LEN      = FFT_LEN_DEF,
    parameter int CP_NORM      = CP_NORM_DEF,
    parameter int CP_LONG      = CP_LONG_DEF,
    parameter int LONG_CP_SYMB = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_slot_head,
    input  logic        i_symb_head,
    input  logic [7:0]  i_slot_num,
    input  logic [3:0]  i_symb_num,
    input  logic        i_iq_vld,
    input  logic [31:0] i_iq_data,
    output logic        o_iq_vld,
    output logic [31:0] o_iq_data,
    output logic        o_sop,
    output logic        o_eop,
    output logic [7:0]  o_slot_num,
    output logic [3:0]  o_symb_num,
    output logic        o_err_align,
    output logic [15:0] o_err_cnt
);

    localparam logic [SAMP_CNT_W-1:0] FFT_LAST     = SAMP_CNT_W'(FFT_LEN - 1);
    localparam logic [SAMP_CNT_W-1:0] CP_NORM_LAST = SAMP_CNT_W'(CP_NORM - 1);
    localparam logic [SAMP_CNT_W-1:0] CP_LONG_LAST = SAMP_CNT_W'(CP_LONG - 1);
    localparam logic [3:0]            LONG_SYMB    = 4'(LONG_CP_SYMB);

    win_state_t            state, state_nxt;
    logic [SAMP_CNT_W-1:0] samp_cnt;
    logic [SAMP_CNT_W-1:0] cp_last;
    logic                  in_window;
    logic                  body_last;
    logic                  cp_done;
    logic                  symb_start;
    logic                  misalign;
    logic                  head_samp;
    logic                  fwd;
    logic                  sop_d;
    logic                  eop_d;

    // A head that lands on the final body sample closes the old window first,
    // so that cycle's sample is not counted as CP sample 0 of the new symbol.
    always_comb begin
        in_window  = (state == ST_CP) || (state == ST_BODY);
        body_last  = (state == ST_BODY) && i_iq_vld && (samp_cnt == FFT_LAST);
        cp_done    = (state == ST_CP) && i_iq_vld && (samp_cnt == cp_last);
        symb_start = i_enable && i_symb_head &&
                     (in_window || (state == ST_GAP) ||
                      ((state == ST_WAIT_SLOT) && i_slot_head));
        misalign   = symb_start && in_window && !body_last;
        head_samp  = symb_start && i_iq_vld && !body_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = ST_IDLE;
        end else if (symb_start) begin
            state_nxt = ST_CP;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_WAIT_SLOT;
                ST_CP:   if (cp_done)   state_nxt = ST_BODY;
                ST_BODY: if (body_last) state_nxt = ST_GAP;
                default: state_nxt = state;
            endcase
        end
    end

    always_comb begin
        fwd   = i_enable && (state == ST_BODY) && i_iq_vld && !misalign;
        sop_d = fwd && (samp_cnt == '0);
        eop_d = fwd && body_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_cnt   <= '0;
            cp_last    <= '0;
            o_iq_vld   <= 1'b0;
            o_iq_data  <= '0;
            o_sop      <= 1'b0;
            o_eop      <= 1'b0;
            o_slot_num <= '0;
            o_symb_num <= '0;
        end else begin
            o_iq_vld <= fwd;
            o_sop    <= sop_d;
            o_eop    <= eop_d;
            if (fwd) begin
                o_iq_data <= i_iq_data;
            end
            if (symb_start) begin
                o_slot_num <= i_slot_num;
                o_symb_num <= i_symb_num;
                cp_last    <= (i_symb_num == LONG_SYMB) ? CP_LONG_LAST : CP_NORM_LAST;
                samp_cnt   <= head_samp ? SAMP_CNT_W'(1) : '0;
            end else if (i_iq_vld && in_window) begin
                samp_cnt <= (cp_done || body_last) ? '0 : samp_cnt + SAMP_CNT_W'(1);
            end
        end
    end

`ifdef UL_SYMB_WIN_ERR_CNT_EN
    logic        err_align_q;
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_align_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_align_q <= misalign;
            if (misalign && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign o_err_align = err_align_q;
    assign o_err_cnt   = err_cnt_q;
`else
    assign o_err_align = 1'b0;
    assign o_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_ul_symb_window_gen.sv
// tb/tb_ul_symb_window_gen.sv - directed vector bench for ul_symb_window_gen (scaled window sizes)
module tb_ul_symb_window_gen;

    localparam int FFT = 32;
    localparam int CPN = 5;
    localparam int CPL = 7;
`ifdef UL_SYMB_WIN_ERR_CNT_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_slot_head;
    logic        i_symb_head;
    logic [7:0]  i_slot_num;
    logic [3:0]  i_symb_num;
    logic        i_iq_vld;
    logic [31:0] i_iq_data;
    logic        o_iq_vld;
    logic [31:0] o_iq_data;
    logic        o_sop;
    logic        o_eop;
    logic [7:0]  o_slot_num;
    logic [3:0]  o_symb_num;
    logic        o_err_align;
    logic [15:0] o_err_cnt;

    ul_symb_window_gen #(
        .FFT_LEN(FFT), .CP_NORM(CPN), .CP_LONG(CPL), .LONG_CP_SYMB(0)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_slot_head(i_slot_head), .i_symb_head(i_symb_head),
        .i_slot_num(i_slot_num), .i_symb_num(i_symb_num),
        .i_iq_vld(i_iq_vld), .i_iq_data(i_iq_data),
        .o_iq_vld(o_iq_vld), .o_iq_data(o_iq_data),
        .o_sop(o_sop), .o_eop(o_eop),
        .o_slot_num(o_slot_num), .o_symb_num(o_symb_num),
        .o_err_align(o_err_align), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    int          tot_vld = 0, tot_sop = 0, tot_eop = 0, tot_err = 0, tot_bad = 0;
    logic [31:0] sop_data = '0, last_data = '0, eop_data = '0;

    always @(negedge clk) begin
        if (o_iq_vld) begin tot_vld++; last_data = o_iq_data; end
        if (o_sop) begin tot_sop++; sop_data = o_iq_data; end
        if (o_eop) begin tot_eop++; eop_data = o_iq_data; end
        if (o_err_align) tot_err++;
        if ((o_sop || o_eop) && !o_iq_vld) tot_bad++;
    end

    typedef struct {
        int symb; int slot; bit slot_hd; int n;
        int nbody; int nsop; int neop; int first; int last;
        int err; int errcnt; int tag_symb; int tag_slot;
    } vec_t;

    vec_t vecs[12];
    int   s_vld, s_sop, s_eop, s_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        s_vld = tot_vld; s_sop = tot_sop; s_eop = tot_eop; s_err = tot_err;
    endtask

    function automatic logic [31:0] tag_data(input int symb, input int k);
        return {16'(symb), 16'(k)};
    endfunction

    // One symbol period: head on the first sample, one sample every 2nd cycle.
    task automatic drive_symb(input int symb, input int slot, input bit slot_hd, input int n);
        for (int k = 0; k < n; k++) begin
            i_symb_head = (k == 0);
            i_slot_head = (k == 0) && slot_hd;
            i_symb_num  = 4'(symb);
            i_slot_num  = 8'(slot);
            i_iq_vld    = 1'b1;
            i_iq_data   = tag_data(symb, k);
            tick();
            i_symb_head = 1'b0;
            i_slot_head = 1'b0;
            i_iq_vld    = 1'b0;
            tick();
        end
    endtask

    initial begin
        int nsat;

        vecs[0]  = '{11, 4, 0, CPN+FFT,   0, 0, 0, 0, 0,          0, 0,  0, 0};
        vecs[1]  = '{12, 4, 0, CPN+FFT,   0, 0, 0, 0, 0,          0, 0,  0, 0};
        vecs[2]  = '{13, 4, 0, CPN+FFT,   0, 0, 0, 0, 0,          0, 0,  0, 0};
        vecs[3]  = '{0,  5, 1, CPL+FFT,   FFT, 1, 1, CPL, CPL+FFT-1, 0, 0,  0, 5};
        vecs[4]  = '{1,  5, 0, CPN+FFT,   FFT, 1, 1, CPN, CPN+FFT-1, 0, 0,  1, 5};
        vecs[5]  = '{2,  5, 0, CPN+10,    10,  1, 0, CPN, CPN+9,     0, 0,  2, 5};
        vecs[6]  = '{3,  5, 0, CPN+FFT,   FFT, 1, 1, CPN, CPN+FFT-1, 1, 1,  3, 5};
        vecs[7]  = '{4,  5, 0, CPN+FFT+6, FFT, 1, 1, CPN, CPN+FFT-1, 0, 1,  4, 5};
        vecs[8]  = '{13, 5, 0, CPN+FFT,   FFT, 1, 1, CPN, CPN+FFT-1, 0, 1, 13, 5};
        vecs[9]  = '{0,  6, 1, CPL+FFT,   FFT, 1, 1, CPL, CPL+FFT-1, 0, 1,  0, 6};
        vecs[10] = '{1,  6, 0, 3,         0,   0, 0, 0,   0,         0, 1,  1, 6};
        vecs[11] = '{2,  6, 0, CPN+FFT,   FFT, 1, 1, CPN, CPN+FFT-1, 1, 2,  2, 6};

        rst = 1'b1; i_enable = 1'b0; i_slot_head = 1'b0; i_symb_head = 1'b0;
        i_slot_num = '0; i_symb_num = '0; i_iq_vld = 1'b0; i_iq_data = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst o_iq_vld", o_iq_vld, 0);
        check("rst o_iq_data", o_iq_data, 0);
        check("rst o_sop", o_sop, 0);
        check("rst o_eop", o_eop, 0);
        check("rst o_slot_num", o_slot_num, 0);
        check("rst o_symb_num", o_symb_num, 0);
        check("rst o_err_align", o_err_align, 0);
        check("rst o_err_cnt", o_err_cnt, 0);
        tick();
        rst = 1'b0;
        i_enable = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            snap();
            drive_symb(vecs[i].symb, vecs[i].slot, vecs[i].slot_hd, vecs[i].n);
            repeat (3) tick();
            check($sformatf("v%0d nbody", i), tot_vld - s_vld, vecs[i].nbody);
            check($sformatf("v%0d nsop", i), tot_sop - s_sop, vecs[i].nsop);
            check($sformatf("v%0d neop", i), tot_eop - s_eop, vecs[i].neop);
            if (vecs[i].nbody > 0) begin
                check($sformatf("v%0d first", i), sop_data, tag_data(vecs[i].symb, vecs[i].first));
                check($sformatf("v%0d last", i), last_data, tag_data(vecs[i].symb, vecs[i].last));
            end
            check($sformatf("v%0d err pulses", i), tot_err - s_err, ERR_EN * vecs[i].err);
            check($sformatf("v%0d err_cnt", i), o_err_cnt, ERR_EN * vecs[i].errcnt);
            check($sformatf("v%0d symb tag", i), o_symb_num, vecs[i].tag_symb);
            check($sformatf("v%0d slot tag", i), o_slot_num, vecs[i].tag_slot);
        end

        // Next head coincides with the final body sample of symbol 3.
        snap();
        for (int k = 0; k < CPN + FFT; k++) begin
            i_symb_head = (k == 0) || (k == CPN + FFT - 1);
            i_symb_num  = (k == CPN + FFT - 1) ? 4'd4 : 4'd3;
            i_slot_num  = 8'd6;
            i_iq_vld    = 1'b1;
            i_iq_data   = tag_data(3, k);
            tick();
            i_symb_head = 1'b0;
            i_iq_vld    = 1'b0;
            tick();
        end
        tick();
        check("coll eop data A", eop_data, tag_data(3, CPN + FFT - 1));
        for (int k = 0; k < CPN + FFT; k++) begin
            i_iq_vld  = 1'b1;
            i_iq_data = tag_data(4, k);
            tick();
            i_iq_vld  = 1'b0;
            tick();
        end
        repeat (3) tick();
        check("coll nbody", tot_vld - s_vld, 2 * FFT);
        check("coll nsop", tot_sop - s_sop, 2);
        check("coll neop", tot_eop - s_eop, 2);
        check("coll first B", sop_data, tag_data(4, CPN));
        check("coll eop data B", eop_data, tag_data(4, CPN + FFT - 1));
        check("coll err pulses", tot_err - s_err, 0);
        check("coll err_cnt", o_err_cnt, ERR_EN * 2);
        check("coll symb tag", o_symb_num, 4);

        // Enable drop on body sample 20.
        snap();
        for (int k = 0; k <= CPN + 20; k++) begin
            i_symb_head = (k == 0);
            i_symb_num  = 4'd5;
            i_iq_vld    = 1'b1;
            i_iq_data   = tag_data(5, k);
            if (k == CPN + 20) i_enable = 1'b0;
            tick();
            i_symb_head = 1'b0;
            i_iq_vld    = 1'b0;
            if (k == CPN + 20) begin
                @(negedge clk);
                check("en drop o_iq_vld", o_iq_vld, 0);
            end
            tick();
        end
        repeat (3) tick();
        check("en drop nbody", tot_vld - s_vld, 20);
        check("en drop neop", tot_eop - s_eop, 0);
        check("en drop last", last_data, tag_data(5, CPN + 19));
        check("en drop err_cnt", o_err_cnt, ERR_EN * 2);

        // Reset on body sample 20.
        i_enable = 1'b1;
        tick();
        tick();
        snap();
        for (int k = 0; k <= CPL + 20; k++) begin
            i_symb_head = (k == 0);
            i_slot_head = (k == 0);
            i_symb_num  = 4'd0;
            i_slot_num  = 8'd7;
            i_iq_vld    = 1'b1;
            i_iq_data   = tag_data(0, k);
            if (k == CPL + 20) rst = 1'b1;
            tick();
            i_symb_head = 1'b0;
            i_slot_head = 1'b0;
            i_iq_vld    = 1'b0;
            if (k == CPL + 20) begin
                @(negedge clk);
                check("rst mid o_iq_vld", o_iq_vld, 0);
                check("rst mid o_iq_data", o_iq_data, 0);
                check("rst mid o_slot_num", o_slot_num, 0);
                check("rst mid o_err_cnt", o_err_cnt, 0);
            end
            tick();
        end
        rst = 1'b0;
        check("rst mid nbody", tot_vld - s_vld, 20);
        check("rst mid neop", tot_eop - s_eop, 0);
        tick();
        tick();

        // Back-to-back heads while in CP, every one misaligned.
        nsat = (ERR_EN != 0) ? 65537 : 20;
        snap();
        i_symb_head = 1'b1;
        i_slot_head = 1'b1;
        i_symb_num  = 4'd1;
        tick();
        i_slot_head = 1'b0;
        for (int k = 0; k < nsat; k++) tick();
        i_symb_head = 1'b0;
        repeat (3) tick();
        check("sat err_cnt", o_err_cnt, (ERR_EN != 0) ? 16'hFFFF : 0);
        check("sat err pulses", tot_err - s_err, ERR_EN * nsat);
        check("sat nbody", tot_vld - s_vld, 0);
        check("marker without valid", tot_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
